// File: rtl/corelet_pkg.sv
// ============================================================================
//  Module   : corelet_pkg
//  Purpose  : Shared state encoding, instruction bit map and helpers for the
//             corelet sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package corelet_pkg;

  localparam int INST_W        = 34;
  localparam int INST_KLOAD    = 0;
  localparam int INST_EXEC     = 1;
  localparam int INST_L0_WR    = 2;
  localparam int INST_L0_RD    = 3;
  localparam int INST_OFIFO_RD = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WFILL = 3'd1,
    ST_KLOAD = 3'd2,
    ST_AFILL = 3'd3,
    ST_EXEC  = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  // Saturating increment used by the optional performance counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/corelet_seq_fill_ctrl.sv
// ============================================================================
//  Module   : fill_ctrl
//  Purpose  : Issues SRAM reads into L0 and tracks their one-cycle write
//             pipeline; shared by the weight and activation fill phases.
//  Macro    : CORELET_SEQ_PERF_EN adds the blocked_o status output.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fill_ctrl
  import corelet_pkg::*;
#(
  parameter int addr_bw = 11,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [addr_bw-1:0] base_i,
  input  logic [CNT_W-1:0]   count_i,
  input  logic               l0_full_i,
  output logic               xmem_cen_o,
  output logic [addr_bw-1:0] xmem_addr_o,
  output logic               l0_wr_o,
  output logic               done_o
`ifdef CORELET_SEQ_PERF_EN
  ,
  output logic               blocked_o
`endif
);

  logic [addr_bw-1:0] next_addr_q, next_addr_d;
  logic [addr_bw-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic               cen_q, cen_d;
  logic               w_issue;
  logic [CNT_W-1:0]   w_retiring;

  // l0_full carries one spare slot, which absorbs the read already in flight.
  assign w_issue    = (remain_q != '0) && !l0_full_i;
  assign w_retiring = CNT_W'(!cen_q);

  always_comb begin
    next_addr_d = next_addr_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    retired_d   = retired_q;
    total_d     = total_q;
    cen_d       = !w_issue;
    if (w_issue) begin
      addr_d      = next_addr_q;
      next_addr_d = next_addr_q + addr_bw'(1);
      remain_d    = remain_q - CNT_W'(1);
    end
    if (!cen_q) begin
      retired_d = retired_q + CNT_W'(1);
    end
    if (load_i) begin
      next_addr_d = base_i;
      remain_d    = count_i;
      total_d     = count_i;
      retired_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_addr_q <= '0;
      addr_q      <= '0;
      remain_q    <= '0;
      retired_q   <= '0;
      total_q     <= '0;
      cen_q       <= 1'b1;
    end else begin
      next_addr_q <= next_addr_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      retired_q   <= retired_d;
      total_q     <= total_d;
      cen_q       <= cen_d;
    end
  end

  assign xmem_cen_o  = cen_q;
  assign xmem_addr_o = addr_q;
  assign l0_wr_o     = !cen_q;
  assign done_o      = (remain_q == '0) && ((retired_q + w_retiring) == total_q);

`ifdef CORELET_SEQ_PERF_EN
  assign blocked_o = (remain_q != '0) && l0_full_i;
`endif

endmodule

`default_nettype wire

// File: rtl/corelet_seq.sv
// ============================================================================
//  Module   : corelet_seq
//  Purpose  : Layer-pass sequencer: weight fill, kernel load, activation fill,
//             execute and OFIFO drain for one corelet.
//  Macro    : CORELET_SEQ_PERF_EN adds perf_cycles / perf_stalls outputs.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module corelet_seq
  import corelet_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         num_act,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] a_base,
  input  logic               l0_full,
  input  logic               ofifo_valid,
  input  logic               ofifo_full,
  output logic [INST_W-1:0]  inst_q,
  output logic               xmem_cen,
  output logic [addr_bw-1:0] xmem_addr,
  output logic               busy,
  output logic               done
`ifdef CORELET_SEQ_PERF_EN
  ,
  output logic [31:0]        perf_cycles,
  output logic [31:0]        perf_stalls
`endif
);

  localparam logic [7:0] COL8 = 8'(col);

  if (col < 1 || col > 255 || row < 1) begin : g_bad_cfg
    $error("corelet_seq: col must be 1..255 and row must be >= 1");
  end

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          na_q, na_d;
  logic [addr_bw-1:0]  a_base_q, a_base_d;
  logic [INST_W-1:0]   inst_d;

  logic                fill_load;
  logic [addr_bw-1:0]  fill_base;
  logic [7:0]          fill_count;
  logic                fill_wr;
  logic                fill_done;
  logic                w_accept;

`ifdef CORELET_SEQ_PERF_EN
  logic                fill_blocked;
`endif

  fill_ctrl #(
    .addr_bw (addr_bw),
    .CNT_W   (8)
  ) u_fill (
    .clk         (clk),
    .reset       (reset),
    .load_i      (fill_load),
    .base_i      (fill_base),
    .count_i     (fill_count),
    .l0_full_i   (l0_full),
    .xmem_cen_o  (xmem_cen),
    .xmem_addr_o (xmem_addr),
    .l0_wr_o     (fill_wr),
    .done_o      (fill_done)
`ifdef CORELET_SEQ_PERF_EN
    ,
    .blocked_o   (fill_blocked)
`endif
  );

  assign w_accept = (state_q == ST_IDLE) && start && (num_act != 8'd0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    na_d       = na_q;
    a_base_d   = a_base_q;
    inst_d     = '0;
    fill_load  = 1'b0;
    fill_base  = w_base;
    fill_count = COL8;
    // A read in flight this cycle becomes an L0 write on the next cycle.
    inst_d[INST_L0_WR] = fill_wr;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          state_d   = ST_WFILL;
          na_d      = num_act;
          a_base_d  = a_base;
          fill_load = 1'b1;
        end
      end
      ST_WFILL: begin
        if (fill_done) begin
          state_d = ST_KLOAD;
          cnt_d   = 8'd0;
        end
      end
      ST_KLOAD: begin
        inst_d[INST_KLOAD] = 1'b1;
        inst_d[INST_L0_RD] = 1'b1;
        // Loading the activation fill here leaves exactly one empty slot
        // before its first L0 write.
        if (cnt_q == COL8 - 8'd1) begin
          state_d    = ST_AFILL;
          cnt_d      = 8'd0;
          fill_load  = 1'b1;
          fill_base  = a_base_q;
          fill_count = na_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_AFILL: begin
        if (fill_done) begin
          state_d = ST_EXEC;
          cnt_d   = 8'd0;
        end
      end
      ST_EXEC: begin
        if (!ofifo_full) begin
          inst_d[INST_EXEC]  = 1'b1;
          inst_d[INST_L0_RD] = 1'b1;
          if (cnt_q == na_q - 8'd1) begin
            state_d = ST_DRAIN;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (ofifo_valid) begin
          inst_d[INST_OFIFO_RD] = 1'b1;
          if (cnt_q == na_q - 8'd1) begin
            state_d = ST_DONE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      na_q     <= 8'd0;
      a_base_q <= '0;
      inst_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      na_q     <= na_d;
      a_base_q <= a_base_d;
      inst_q   <= inst_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

`ifdef CORELET_SEQ_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [31:0] perf_stalls_q;
  logic        w_stall;

  assign w_stall = ((state_q == ST_EXEC) && ofifo_full) ||
                   (((state_q == ST_WFILL) || (state_q == ST_AFILL)) && fill_blocked);

  // The start cycle counts as the first cycle of the pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles_q <= 32'd0;
      perf_stalls_q <= 32'd0;
    end else if (w_accept) begin
      perf_cycles_q <= 32'd1;
      perf_stalls_q <= 32'd0;
    end else if (state_q != ST_IDLE) begin
      perf_cycles_q <= sat_inc(perf_cycles_q);
      if (w_stall) begin
        perf_stalls_q <= sat_inc(perf_stalls_q);
      end
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

`default_nettype wire
